// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle for adder_share_arbiter: two operand channels plus one tagged result channel.
// rsp_ovf is present only when ADDER_ARB_OVF_EN is defined.
interface adder_share_arbiter_if #(
  parameter int WIDTH = 18
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
`ifdef ADDER_ARB_OVF_EN
  logic             rsp_ovf;
`endif

  // Requesters and the result consumer.
  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    output rsp_ready,
    input  rsp_valid, rsp_id, rsp_sum,
`ifdef ADDER_ARB_OVF_EN
    input  rsp_ovf,
`endif
    input  rsp_cout
  );

  // The arbiter.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    input  rsp_ready,
    output rsp_valid, rsp_id, rsp_sum,
`ifdef ADDER_ARB_OVF_EN
    output rsp_ovf,
`endif
    output rsp_cout
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one WIDTH-bit adder between two requesters, with a settle delay.
// Optional signed-overflow output enabled by defining ADDER_ARB_OVF_EN.
module adder_share_arbiter #(
  parameter int WIDTH         = 18,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  reset,
  adder_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // A settle time of zero still needs one cycle for the registered operands to reach the adder.
  localparam int         SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [3:0] CNT_LOAD   = 4'(SETTLE_EFF - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             rsp_id_q, rsp_id_d;
`ifdef ADDER_ARB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             grant_vld;
  logic             grant_id;
  logic             accept;
  logic [WIDTH:0]   add_full;

  // The adder sees only operand registers, so requester changes after acceptance cannot reach it.
  assign add_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~last_q;
    end else if (bus.req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  assign accept         = (state_q == IDLE) && grant_vld && !reset;
  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept && grant_id;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    id_d     = id_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    rsp_id_d = rsp_id_q;
`ifdef ADDER_ARB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = grant_id ? bus.req1_a   : bus.req0_a;
          b_d     = grant_id ? bus.req1_b   : bus.req0_b;
          cin_d   = grant_id ? bus.req1_cin : bus.req0_cin;
          id_d    = grant_id;
          last_d  = grant_id;
          cnt_d   = CNT_LOAD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          sum_d    = add_full[WIDTH-1:0];
          cout_d   = add_full[WIDTH];
          rsp_id_d = id_q;
`ifdef ADDER_ARB_OVF_EN
          ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
`endif
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      id_q     <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      rsp_id_q <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      id_q     <= id_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      rsp_id_q <= rsp_id_d;
`ifdef ADDER_ARB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
`ifdef ADDER_ARB_OVF_EN
  assign bus.rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed-vector bench for adder_share_arbiter: default settle instance plus a SETTLE_CYCLES=4 instance.
// Overflow checks are compiled in when ADDER_ARB_OVF_EN is defined.
module tb_adder_share_arbiter;
  localparam int W = 18;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
`ifdef ADDER_ARB_OVF_EN
  logic ovf_seen;
`endif

  adder_share_arbiter_if #(.WIDTH(W)) bus_a ();
  adder_share_arbiter_if #(.WIDTH(W)) bus_b ();

  adder_share_arbiter #(.WIDTH(W)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  adder_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    bus_a.req0_valid = 1'b0; bus_a.req0_a = '0; bus_a.req0_b = '0; bus_a.req0_cin = 1'b0;
    bus_a.req1_valid = 1'b0; bus_a.req1_a = '0; bus_a.req1_b = '0; bus_a.req1_cin = 1'b0;
    bus_a.rsp_ready  = 1'b1;
  endtask

  task automatic clear_b();
    bus_b.req0_valid = 1'b0; bus_b.req0_a = '0; bus_b.req0_b = '0; bus_b.req0_cin = 1'b0;
    bus_b.req1_valid = 1'b0; bus_b.req1_a = '0; bus_b.req1_b = '0; bus_b.req1_cin = 1'b0;
    bus_b.rsp_ready  = 1'b1;
  endtask

  // One isolated transaction on the default instance; response expected exactly 2 cycles after accept.
  task automatic single_a(input logic port, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input int exp_sum, input int exp_cout, input string tag);
    int n;
    if (port) begin
      bus_a.req1_a = a; bus_a.req1_b = b; bus_a.req1_cin = cin; bus_a.req1_valid = 1'b1;
    end else begin
      bus_a.req0_a = a; bus_a.req0_b = b; bus_a.req0_cin = cin; bus_a.req0_valid = 1'b1;
    end
    #1;
    check({tag, "_ready"}, 32'(port ? bus_a.req1_ready : bus_a.req0_ready), 1);
    tick();
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    n = 1;
    while (!bus_a.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 2);
    check({tag, "_id"},   32'(bus_a.rsp_id),   32'(port));
    check({tag, "_sum"},  32'(bus_a.rsp_sum),  32'(exp_sum));
    check({tag, "_cout"}, 32'(bus_a.rsp_cout), 32'(exp_cout));
`ifdef ADDER_ARB_OVF_EN
    ovf_seen = bus_a.rsp_ovf;
`endif
    tick();
    check({tag, "_done"}, 32'(bus_a.rsp_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int got;
    int prev;

    // Reset state, with valids asserted to show ready stays low during reset.
    reset = 1'b1;
    clear_a();
    clear_b();
    bus_a.req0_valid = 1'b1;
    bus_a.req1_valid = 1'b1;
    bus_b.req0_valid = 1'b1;
    tick();
    tick();
    check("rst_ready0",    32'(bus_a.req0_ready), 0);
    check("rst_ready1",    32'(bus_a.req1_ready), 0);
    check("rst_rsp_valid", 32'(bus_a.rsp_valid),  0);
    check("rst_rsp_id",    32'(bus_a.rsp_id),     0);
    check("rst_rsp_sum",   32'(bus_a.rsp_sum),    0);
    check("rst_rsp_cout",  32'(bus_a.rsp_cout),   0);
    check("rst_b_ready0",  32'(bus_b.req0_ready), 0);
    check("rst_b_valid",   32'(bus_b.rsp_valid),  0);
`ifdef ADDER_ARB_OVF_EN
    check("rst_rsp_ovf",   32'(bus_a.rsp_ovf),    0);
`endif
    clear_a();
    clear_b();
    reset = 1'b0;
    tick();

    // Arithmetic vectors.
    single_a(1'b0, 18'h00005, 18'h00003, 1'b0, 'h00008, 0, "add");
    single_a(1'b1, 18'h3FFFF, 18'h00000, 1'b1, 'h00000, 1, "wrap");
    single_a(1'b0, 18'h1FFFF, 18'h00001, 1'b0, 'h20000, 0, "posovf");
`ifdef ADDER_ARB_OVF_EN
    check("posovf_ovf", 32'(ovf_seen), 1);
`endif
    single_a(1'b1, 18'h12345, 18'h0ABCD, 1'b0, 'h1CF12, 0, "mix");
`ifdef ADDER_ARB_OVF_EN
    check("mix_ovf", 32'(ovf_seen), 0);
`endif
    single_a(1'b0, 18'h20000, 18'h20000, 1'b0, 'h00000, 1, "negovf");
`ifdef ADDER_ARB_OVF_EN
    check("negovf_ovf", 32'(ovf_seen), 1);
`endif

    // Round-robin under continuous contention right after reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_a.req0_a = 18'h00001; bus_a.req0_b = 18'h00001; bus_a.req0_valid = 1'b1;
    bus_a.req1_a = 18'h00010; bus_a.req1_b = 18'h0000E; bus_a.req1_valid = 1'b1;
    #1;
    check("rr_first_ready0", 32'(bus_a.req0_ready), 1);
    check("rr_first_ready1", 32'(bus_a.req1_ready), 0);
    cyc  = 0;
    got  = 0;
    prev = 0;
    while (got < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (bus_a.rsp_valid) begin
        check("rr_id",  32'(bus_a.rsp_id),  32'(got % 2));
        check("rr_sum", 32'(bus_a.rsp_sum), (got % 2 == 1) ? 'h1E : 'h2);
        check("rr_gap", 32'(cyc - prev), (got == 0) ? 2 : 3);
        prev = cyc;
        got++;
      end
    end
    check("rr_count", 32'(got), 4);
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    tick();
    tick();

    // Backpressure: response held while rsp_ready is low, pending request waits.
    bus_a.rsp_ready  = 1'b0;
    bus_a.req0_a = 18'h00064; bus_a.req0_b = 18'h000C8; bus_a.req0_cin = 1'b0;
    bus_a.req0_valid = 1'b1;
    tick();
    bus_a.req0_valid = 1'b0;
    tick();
    bus_a.req1_a = 18'h00007; bus_a.req1_b = 18'h00008; bus_a.req1_cin = 1'b1;
    bus_a.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid",  32'(bus_a.rsp_valid),  1);
      check("bp_sum",    32'(bus_a.rsp_sum),    'h12C);
      check("bp_id",     32'(bus_a.rsp_id),     0);
      check("bp_ready0", 32'(bus_a.req0_ready), 0);
      check("bp_ready1", 32'(bus_a.req1_ready), 0);
      tick();
    end
    bus_a.rsp_ready = 1'b1;
    tick();
    check("bp_accept_ready1", 32'(bus_a.req1_ready), 1);
    check("bp_accept_ready0", 32'(bus_a.req0_ready), 0);
    tick();
    bus_a.req1_valid = 1'b0;
    tick();
    check("bp_next_valid", 32'(bus_a.rsp_valid), 1);
    check("bp_next_sum",   32'(bus_a.rsp_sum),   'h10);
    check("bp_next_id",    32'(bus_a.rsp_id),    1);
    tick();

    // Reset while EXEC: aborted op never responds, pointer returns to favour port 0.
    bus_a.req0_a = 18'h00005; bus_a.req0_b = 18'h00005; bus_a.req0_valid = 1'b1;
    tick();
    bus_a.req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("rx_rsp_valid", 32'(bus_a.rsp_valid), 0);
    check("rx_rsp_id",    32'(bus_a.rsp_id),    0);
    check("rx_rsp_sum",   32'(bus_a.rsp_sum),   0);
    check("rx_rsp_cout",  32'(bus_a.rsp_cout),  0);
    bus_a.req0_a = 18'h00001; bus_a.req0_b = 18'h00002; bus_a.req0_valid = 1'b1;
    bus_a.req1_a = 18'h00009; bus_a.req1_b = 18'h00009; bus_a.req1_valid = 1'b1;
    #1;
    check("rx_hold_ready0", 32'(bus_a.req0_ready), 0);
    check("rx_hold_ready1", 32'(bus_a.req1_ready), 0);
    reset = 1'b0;
    #1;
    check("rx_grant_ready0", 32'(bus_a.req0_ready), 1);
    check("rx_grant_ready1", 32'(bus_a.req1_ready), 0);
    tick();
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    n = 1;
    while (!bus_a.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("rx_latency", 32'(n), 2);
    check("rx_id",      32'(bus_a.rsp_id),  0);
    check("rx_sum",     32'(bus_a.rsp_sum), 'h3);
    tick();

    // SETTLE_CYCLES=4: response at T+5, operand changes after accept ignored.
    bus_b.req0_a = 18'h00010; bus_b.req0_b = 18'h00020; bus_b.req0_cin = 1'b0;
    bus_b.req0_valid = 1'b1;
    #1;
    check("s4_ready", 32'(bus_b.req0_ready), 1);
    tick();
    bus_b.req0_valid = 1'b0;
    bus_b.req0_a = 18'h3FFFF; bus_b.req0_b = 18'h3FFFF; bus_b.req0_cin = 1'b1;
    n = 1;
    while (!bus_b.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("s4_latency", 32'(n), 5);
    check("s4_sum",     32'(bus_b.rsp_sum),  'h30);
    check("s4_cout",    32'(bus_b.rsp_cout), 0);
    check("s4_id",      32'(bus_b.rsp_id),   0);
    tick();
    check("s4_done",    32'(bus_b.rsp_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
